// File: rtl/watch_mode_ctrl_if.sv
// Button-pulse inputs and counter/FND control outputs of the watch mode controller.
// master = button/debounce side, slave = the controller itself.
interface watch_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_run;
  logic       btn_clear;
  logic       btn_set;
  logic       btn_up;
  logic       disp_sw;
  logic       mode;
  logic       sw_run;
  logic       sw_clear;
  logic       watch_hold;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       disp_sel;
  logic [3:0] blink_mask;

  modport master (
    output btn_mode, btn_run, btn_clear, btn_set, btn_up, disp_sw,
    input  mode, sw_run, sw_clear, watch_hold, inc_hour, inc_min, inc_sec,
           disp_sel, blink_mask
  );

  modport slave (
    input  btn_mode, btn_run, btn_clear, btn_set, btn_up, disp_sw,
    output mode, sw_run, sw_clear, watch_hold, inc_hour, inc_min, inc_sec,
           disp_sel, blink_mask
  );
endinterface

// File: rtl/watch_mode_ctrl.sv
// Mode/sequence controller: button pulses -> stopwatch run/clear, watch edit, page select, blink mask.
// Every output is a flop updated one cycle after the pulse; no backpressure, unaccepted pulses are dropped.
module watch_mode_ctrl #(
  parameter int BLINK_HALF = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  watch_mode_ctrl_if.slave bus
);

  localparam int             CW      = $clog2(BLINK_HALF);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {SW_STOP, SW_RUN, SW_CLR} sw_state_t;
  typedef enum logic [1:0] {W_RUN, W_HOUR, W_MIN, W_SEC} w_state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_MODE, CMD_SET, CMD_CLEAR, CMD_RUN, CMD_UP} cmd_t;

  sw_state_t     sw_state, sw_next;
  w_state_t      w_state, w_next;
  cmd_t          cmd;

  logic          mode_q, mode_next;
  logic [CW-1:0] cnt_q, cnt_next;
  logic          phase_q, phase_next;
  logic          up_accept;

  logic          inc_hour_next, inc_min_next, inc_sec_next;
  logic          disp_sel_next;
  logic [3:0]    blink_mask_next;

  logic          sw_run_q, sw_clear_q, watch_hold_q;
  logic          inc_hour_q, inc_min_q, inc_sec_q;
  logic          disp_sel_q;
  logic [3:0]    blink_mask_q;

  // Only the highest-priority pulse survives, even if the state then ignores it.
  always_comb begin
    cmd = CMD_NONE;
    if (bus.btn_mode)       cmd = CMD_MODE;
    else if (bus.btn_set)   cmd = CMD_SET;
    else if (bus.btn_clear) cmd = CMD_CLEAR;
    else if (bus.btn_run)   cmd = CMD_RUN;
    else if (bus.btn_up)    cmd = CMD_UP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_state <= SW_STOP;
      w_state  <= W_RUN;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      sw_state <= sw_next;
      w_state  <= w_next;
      mode_q   <= mode_next;
      cnt_q    <= cnt_next;
      phase_q  <= phase_next;
    end
  end

  always_comb begin
    sw_next       = sw_state;
    w_next        = w_state;
    mode_next     = mode_q;
    up_accept     = 1'b0;
    inc_hour_next = 1'b0;
    inc_min_next  = 1'b0;
    inc_sec_next  = 1'b0;

    case (cmd)
      CMD_MODE: begin
        if ((!mode_q && sw_state == SW_STOP) || (mode_q && w_state == W_RUN))
          mode_next = ~mode_q;
      end
      CMD_SET: begin
        if (mode_q) begin
          case (w_state)
            W_RUN:   w_next = W_HOUR;
            W_HOUR:  w_next = W_MIN;
            W_MIN:   w_next = W_SEC;
            default: w_next = W_RUN;
          endcase
        end
      end
      CMD_CLEAR: begin
        if (!mode_q && sw_state == SW_STOP)
          sw_next = SW_CLR;
      end
      CMD_RUN: begin
        if (!mode_q) begin
          if (sw_state == SW_STOP)     sw_next = SW_RUN;
          else if (sw_state == SW_RUN) sw_next = SW_STOP;
        end
      end
      CMD_UP: begin
        if (mode_q) begin
          case (w_state)
            W_HOUR: begin inc_hour_next = 1'b1; up_accept = 1'b1; end
            W_MIN:  begin inc_min_next  = 1'b1; up_accept = 1'b1; end
            W_SEC:  begin inc_sec_next  = 1'b1; up_accept = 1'b1; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase

    // Clear is a single-cycle state regardless of what else arrives.
    if (sw_state == SW_CLR)
      sw_next = SW_STOP;
  end

  // Blink timer restarts visible on field entry or an accepted increment.
  always_comb begin
    cnt_next   = '0;
    phase_next = 1'b1;
    if (w_next != W_RUN) begin
      if (w_next != w_state || up_accept) begin
        cnt_next   = '0;
        phase_next = 1'b1;
      end else if (cnt_q == CNT_MAX) begin
        cnt_next   = '0;
        phase_next = ~phase_q;
      end else begin
        cnt_next   = cnt_q + 1'b1;
        phase_next = phase_q;
      end
    end
  end

  always_comb begin
    blink_mask_next = 4'b0000;
    if (!phase_next) begin
      case (w_next)
        W_HOUR:  blink_mask_next = 4'b1100;
        W_MIN:   blink_mask_next = 4'b0011;
        W_SEC:   blink_mask_next = 4'b1100;
        default: blink_mask_next = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (w_next)
      W_HOUR, W_MIN: disp_sel_next = 1'b1;
      W_SEC:         disp_sel_next = 1'b0;
      default:       disp_sel_next = bus.disp_sw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_run_q     <= 1'b0;
      sw_clear_q   <= 1'b0;
      watch_hold_q <= 1'b0;
      inc_hour_q   <= 1'b0;
      inc_min_q    <= 1'b0;
      inc_sec_q    <= 1'b0;
      disp_sel_q   <= 1'b0;
      blink_mask_q <= 4'b0000;
    end else begin
      sw_run_q     <= (sw_next == SW_RUN);
      sw_clear_q   <= (sw_next == SW_CLR);
      watch_hold_q <= (w_next != W_RUN);
      inc_hour_q   <= inc_hour_next;
      inc_min_q    <= inc_min_next;
      inc_sec_q    <= inc_sec_next;
      disp_sel_q   <= disp_sel_next;
      blink_mask_q <= blink_mask_next;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.sw_run     = sw_run_q;
  assign bus.sw_clear   = sw_clear_q;
  assign bus.watch_hold = watch_hold_q;
  assign bus.inc_hour   = inc_hour_q;
  assign bus.inc_min    = inc_min_q;
  assign bus.inc_sec    = inc_sec_q;
  assign bus.disp_sel   = disp_sel_q;
  assign bus.blink_mask = blink_mask_q;

endmodule
